// File: rtl/par_dev_bridge_if.sv
// Request-side bus of par_dev_bridge: word-wide read/write requests held until
// done, plus the busy/done/rdata response.
interface par_dev_bridge_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 1
);
  logic                  req_rd;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic [BUS_WIDTH-1:0]  req_wdata;
  logic                  busy;
  logic                  done;
  logic [BUS_WIDTH-1:0]  rdata;

  modport master (
    output req_rd, req_wr, req_addr, req_size, req_wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_size, req_wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/par_dev_bridge.sv
// Splits word requests into 1/2/4 timed device beats, drives the device reset
// pulse and synchronises dev_intrq. Define PAR_DEV_READY_EN for dev_ready/err.
module par_dev_bridge #(
  parameter int BUS_WIDTH     = 32,
  parameter int DEV_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 1,
  parameter int SETUP_CYC     = 1,
  parameter int STROBE_CYC    = 4,
  parameter int HOLD_CYC      = 1,
  parameter int RECOVER_CYC   = 4,
  parameter int ADDR_INC      = 0,
  parameter int RST_PULSE_CYC = 16
`ifdef PAR_DEV_READY_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  par_dev_bridge_if.slave       bus,
  output logic                  irq,
  output logic                  dev_cs_n,
  output logic                  dev_rd_n,
  output logic                  dev_wr_n,
  output logic [ADDR_WIDTH-1:0] dev_addr,
  output logic [DEV_WIDTH-1:0]  dev_dout,
  output logic                  dev_oe,
  input  logic [DEV_WIDTH-1:0]  dev_din,
  output logic                  dev_rst_n,
  input  logic                  dev_intrq
`ifdef PAR_DEV_READY_EN
  , input  logic                dev_ready
  , output logic                err
`endif
);

  localparam int unsigned MAX_BEATS = BUS_WIDTH / DEV_WIDTH;
  localparam int          CW        = 16;

  typedef enum logic [2:0] {RSTP, IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   is_rd;
  logic [1:0]             beat;
  logic [1:0]             last;
  logic [BUS_WIDTH-1:0]   wdata_lat;
  logic [BUS_WIDTH-1:0]   rbuf;
  logic                   intrq_s1;
  logic                   strobe_ok;
  logic                   strobe_to;

  function automatic logic [1:0] last_beat(input logic [1:0] size);
    int unsigned n;
    case (size)
      2'd1:    n = 2;
      2'd2:    n = 4;
      default: n = 1;
    endcase
    if (n > MAX_BEATS) n = MAX_BEATS;
    return 2'(n - 1);
  endfunction

`ifdef PAR_DEV_READY_EN
  logic          rdy_s1, rdy_s2;
  logic [CW-1:0] tcnt;
  logic          err_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_s1 <= 1'b0;
      rdy_s2 <= 1'b0;
    end else begin
      rdy_s1 <= dev_ready;
      rdy_s2 <= rdy_s1;
    end
  end

  // Release needs both the minimum strobe width and a synchronised ready.
  always_comb begin
    strobe_ok = (cnt == '0) && rdy_s2;
    strobe_to = !strobe_ok && (tcnt == CW'(TIMEOUT_CYC - 1));
  end
`else
  always_comb begin
    strobe_ok = (cnt == '0);
    strobe_to = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intrq_s1 <= 1'b0;
      irq      <= 1'b0;
    end else begin
      intrq_s1 <= dev_intrq;
      irq      <= intrq_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RSTP;
      cnt       <= CW'(RST_PULSE_CYC - 1);
      bus.busy  <= 1'b1;
      bus.done  <= 1'b0;
      bus.rdata <= '0;
      dev_cs_n  <= 1'b1;
      dev_rd_n  <= 1'b1;
      dev_wr_n  <= 1'b1;
      dev_addr  <= '0;
      dev_dout  <= '0;
      dev_oe    <= 1'b0;
      dev_rst_n <= 1'b0;
      is_rd     <= 1'b0;
      beat      <= '0;
      last      <= '0;
      wdata_lat <= '0;
      rbuf      <= '0;
`ifdef PAR_DEV_READY_EN
      tcnt      <= '0;
      err_pend  <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
`ifdef PAR_DEV_READY_EN
      err <= 1'b0;
      if (state != STROBE) tcnt <= '0;
`endif
      case (state)
        RSTP: begin
          if (cnt == '0) begin
            dev_rst_n <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        IDLE: begin
          if (bus.req_rd || bus.req_wr) begin
            is_rd     <= bus.req_rd;
            last      <= last_beat(bus.req_size);
            beat      <= '0;
            dev_addr  <= bus.req_addr;
            wdata_lat <= bus.req_wdata;
            dev_dout  <= bus.req_wdata[DEV_WIDTH-1:0];
            rbuf      <= '0;
            bus.busy  <= 1'b1;
            dev_cs_n  <= 1'b0;
            dev_oe    <= !bus.req_rd;
`ifdef PAR_DEV_READY_EN
            err_pend  <= 1'b0;
`endif
            if (SETUP_CYC > 0) begin
              state <= SETUP;
              cnt   <= CW'(SETUP_CYC - 1);
            end else begin
              state    <= STROBE;
              cnt      <= CW'(STROBE_CYC - 1);
              dev_rd_n <= !bus.req_rd;
              dev_wr_n <= bus.req_rd;
            end
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            state    <= STROBE;
            cnt      <= CW'(STROBE_CYC - 1);
            dev_rd_n <= !is_rd;
            dev_wr_n <= is_rd;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STROBE: begin
          if (strobe_ok || strobe_to) begin
            dev_rd_n <= 1'b1;
            dev_wr_n <= 1'b1;
            if (is_rd && !strobe_to)
              rbuf[int'(beat)*DEV_WIDTH +: DEV_WIDTH] <= dev_din;
`ifdef PAR_DEV_READY_EN
            // Timeout ends the access after this beat; unread lanes read as ones.
            if (strobe_to) begin
              last     <= beat;
              err_pend <= 1'b1;
              if (is_rd)
                for (int unsigned i = 0; i < MAX_BEATS; i++)
                  if (i >= 32'(beat) && i <= 32'(last))
                    rbuf[i*DEV_WIDTH +: DEV_WIDTH] <= '1;
            end
`endif
            if (HOLD_CYC > 0) begin
              state <= HOLD;
              cnt   <= CW'(HOLD_CYC - 1);
            end else begin
              state    <= RECOVER;
              cnt      <= CW'(RECOVER_CYC - 1);
              dev_cs_n <= 1'b1;
              dev_oe   <= 1'b0;
            end
          end else begin
            if (cnt != '0) cnt <= cnt - 1'b1;
`ifdef PAR_DEV_READY_EN
            tcnt <= tcnt + 1'b1;
`endif
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            state    <= RECOVER;
            cnt      <= CW'(RECOVER_CYC - 1);
            dev_cs_n <= 1'b1;
            dev_oe   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RECOVER: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (beat != last) begin
            beat     <= beat + 1'b1;
            dev_dout <= wdata_lat[(int'(beat) + 1)*DEV_WIDTH +: DEV_WIDTH];
            dev_cs_n <= 1'b0;
            dev_oe   <= !is_rd;
            if (ADDR_INC != 0) dev_addr <= dev_addr + 1'b1;
            if (SETUP_CYC > 0) begin
              state <= SETUP;
              cnt   <= CW'(SETUP_CYC - 1);
            end else begin
              state    <= STROBE;
              cnt      <= CW'(STROBE_CYC - 1);
              dev_rd_n <= !is_rd;
              dev_wr_n <= is_rd;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            if (is_rd) bus.rdata <= rbuf;
`ifdef PAR_DEV_READY_EN
            err <= err_pend;
`endif
          end
        end

        default: state <= RSTP;
      endcase
    end
  end

endmodule

// File: doc/par_dev_bridge.md
Name: par_dev_bridge

Overview:
- Parametrised successor to the single-byte peripheral strobe controller.
- Bridges a synchronous word-wide request interface to an external asynchronous parallel device: chip select, read/write strobes, address lines, data bus of DEV_WIDTH bits.
- Splits one bus access into 1/2/4 device beats with programmable setup/strobe/hold/recovery timing.
- Generates the device power-on reset pulse and synchronises the device interrupt line.

Parameters:
- BUS_WIDTH, 32, request-side data width; multiple of DEV_WIDTH.
- DEV_WIDTH, 8, device data width.
- ADDR_WIDTH, 1, device address width.
- SETUP_CYC, 1, cycles with cs_n low before strobe; 0 allowed, phase skipped.
- STROBE_CYC, 4, strobe-low cycles; min 1.
- HOLD_CYC, 1, cycles with cs_n low after strobe release; 0 allowed, phase skipped.
- RECOVER_CYC, 4, cs_n-high cycles between beats; min 1.
- ADDR_INC, 0, 1 = device address increments per beat; 0 = constant (FIFO-style port).
- RST_PULSE_CYC, 16, dev_rst_n low cycles after rst release.

Ports:
- clk, in, 1, bridge clock.
- rst, in, 1, asynchronous active-high reset.
- req_rd, in, 1, read request; held by master until done.
- req_wr, in, 1, write request; held by master until done.
- req_addr, in, ADDR_WIDTH, device start address.
- req_size, in, 2, 0=1 beat, 1=2 beats, 2=4 beats, 3=reserved (treated as 0); clamped to BUS_WIDTH/DEV_WIDTH.
- req_wdata, in, BUS_WIDTH, write data; beat i = bits [i*DEV_WIDTH +: DEV_WIDTH].
- busy, out, 1, high while access or reset pulse in progress.
- done, out, 1, one-cycle completion pulse.
- rdata, out, BUS_WIDTH, read data; little-endian beat packing.
- irq, out, 1, synchronised interrupt.
- dev_cs_n / dev_rd_n / dev_wr_n, out, 1 each, device strobes.
- dev_addr, out, ADDR_WIDTH, device address.
- dev_dout, out, DEV_WIDTH, device write data.
- dev_oe, out, 1, tristate enable for dev_dout (pad tristate lives at top level).
- dev_din, in, DEV_WIDTH, device read data.
- dev_rst_n, out, 1, device reset.
- dev_intrq, in, 1, device interrupt, asynchronous, active-high.

Behaviour:
- All outputs registered.
- Reset values: busy=1, done=0, rdata=0, irq=0, cs_n/rd_n/wr_n=1, dev_addr=0, dev_dout=0, dev_oe=0, dev_rst_n=0.
- States: RSTP, IDLE, SETUP, STROBE, HOLD, RECOVER.
- RSTP:
  - Entered on rst; dev_rst_n=0, busy=1.
  - After RST_PULSE_CYC cycles: dev_rst_n=1, busy=0, go IDLE.
  - Requests during RSTP are ignored; master holds them.
- IDLE request sampling:
  - Sampled at each edge while busy=0.
  - req_rd and req_wr both high: read wins.
  - Latch addr, wdata, beat count N, direction; busy<=1; go SETUP (or STROBE if SETUP_CYC=0).
- SETUP: cs_n=0, strobes high, dev_addr valid; writes: dev_oe=1 and dev_dout = current beat.
- STROBE:
  - Read: rd_n=0; write: wr_n=0.
  - At the edge ending the last STROBE cycle: strobe released; read captures dev_din into the beat lane of rdata.
- HOLD: cs_n=0, strobes high, write data and dev_oe held.
- RECOVER:
  - cs_n=1, dev_oe=0.
  - If beats remain: advance beat index; dev_addr += 1 when ADDR_INC=1; go SETUP.
  - Otherwise: go IDLE, done=1 for one cycle, busy=0 at that same edge.
- Latency: done rises exactly N*(SETUP_CYC+STROBE_CYC+HOLD_CYC+RECOVER_CYC) edges after the sampling edge.
- rdata:
  - Lanes not read this access are zeroed.
  - Holds until the next read's done.
  - Unchanged by writes.
- Requests while busy are ignored; no queueing.
- dev_addr wrap-around is modulo 2^ADDR_WIDTH.
- rst mid-access: strobes released immediately (asynchronously), access abandoned, no done, RSTP re-run.
- irq: two-flop synchroniser of dev_intrq, level-following; 2-3 cycle latency.

Optional Feature:
- Macro: PAR_DEV_READY_EN.
- When defined:
  - Adds input dev_ready (1 bit, active-high), two-flop synchronised.
  - Adds parameter TIMEOUT_CYC (default 64).
  - Adds output err (1 bit).
  - STROBE extends beyond STROBE_CYC until synchronised ready=1; capture/release happens at the edge where ready is seen and the minimum count has elapsed.
  - If strobe has been low TIMEOUT_CYC cycles without ready: release strobe; remaining beats skipped; read lane filled with all ones; done pulses with err=1; err otherwise 0.
- When undefined: no dev_ready or err ports; fixed timing only.

Test Plan:
- Reset release: dev_rst_n low exactly 16 cycles, busy high over the same window; req_rd held from cycle 0 is serviced after the pulse.
- Single-byte write, size=0, addr=1, wdata=0xA5: cs_n low 6 cycles, wr_n low cycles 2-5, dev_oe high while cs_n low, dev_dout=0xA5; done at edge 10.
- 4-beat read, ADDR_INC=1, device returns 0x11,0x22,0x33,0x44 at addr 0..3: rdata=0x44332211; done at edge 40; 4 cs_n pulses each separated by 4 high cycles.
- 2-beat read, ADDR_INC=0, following the previous read: dev_addr constant; rdata upper 16 bits = 0.
- Simultaneous req_rd+req_wr: read performed, wr_n never asserted; dev_intrq pulse of 3 cycles gives irq high for 3 cycles, delayed 2-3 cycles.
- PAR_DEV_READY_EN defined: ready held low gives timeout at TIMEOUT_CYC with err=1, rdata=0xFFFFFFFF; ready rising at strobe cycle 7 gives capture at that edge, err=0.
